// File: rtl/snake_pkg.sv
// Shared types and IDLE-layout constants for the snake game engine.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PLACE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;
    localparam logic [3:0] INIT_DIR  = DIR_RIGHT;

    function automatic int idleHeadX(input int gridW);
        return gridW / 2;
    endfunction

    function automatic int idleHeadY(input int gridH);
        return gridH / 2;
    endfunction

    function automatic int idleAppleX(input int gridW);
        return gridW * 3 / 4;
    endfunction

    // Unused storage slots sit on the tail cell, so growth simply keeps the tail in place.
    function automatic int idleSegX(input int gridW, input int initLen, input int idx);
        return gridW / 2 - ((idx < initLen) ? idx : initLen - 1);
    endfunction

    function automatic logic [3:0] oppositeDir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Parallel compare of one cell against every segment, masked to the first 'count' entries.
module snake_seg_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int LW      = 5
) (
    input  logic [XW-1:0]      cellX,
    input  logic [YW-1:0]      cellY,
    input  logic [XW-1:0]      segX [MAX_LEN],
    input  logic [YW-1:0]      segY [MAX_LEN],
    input  logic [LW-1:0]      count,
    output logic [MAX_LEN-1:0] match
);

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
        assign match[i] = (segX[i] == cellX) && (segY[i] == cellY) && (count > LW'(i));
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: movement, collision, apple placement and cell queries.
// Define SNAKE_WRAP_EN to make the snake wrap around the walls instead of dying.
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         start,
    input  logic [3:0]                   dir_req,
    input  logic [9:0]                   rand_x,
    input  logic [8:0]                   rand_y,
    input  logic [$clog2(GRID_W)-1:0]    query_x,
    input  logic [$clog2(GRID_H)-1:0]    query_y,
    output logic                         hit_head,
    output logic                         hit_body,
    output logic                         hit_apple,
    output logic [$clog2(GRID_W)-1:0]    apple_x,
    output logic [$clog2(GRID_H)-1:0]    apple_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [7:0]                   score,
    output logic [1:0]                   state,
    output logic                         ate
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [XW:0] ONE_X = 1;
    localparam logic [YW:0] ONE_Y = 1;

    state_t         curState, nextState;
    logic [XW-1:0]  segX [MAX_LEN];
    logic [YW-1:0]  segY [MAX_LEN];
    logic [3:0]     curDir, pendDir;
    logic [LW-1:0]  lenReg;
    logic [7:0]     scoreReg;
    logic [XW-1:0]  appleX;
    logic [YW-1:0]  appleY;
    logic           ateReg;

    logic [XW:0]    wideX;
    logic [YW:0]    wideY;
    logic [XW-1:0]  nextX;
    logic [YW-1:0]  nextY;
    logic           offGrid, eatHit, grow, selfHit, candHit, validReq, restart;
    logic [LW-1:0]  collCount;
    logic [XW-1:0]  candX;
    logic [YW-1:0]  candY;
    logic [MAX_LEN-1:0] bodyVec, queryVec, candVec;

    // Next head is computed one bit wider so stepping past either wall is visible.
    always_comb begin
        wideX = {1'b0, segX[0]};
        wideY = {1'b0, segY[0]};
        case (pendDir)
            DIR_LEFT:  wideX = wideX - ONE_X;
            DIR_RIGHT: wideX = wideX + ONE_X;
            DIR_UP:    wideY = wideY - ONE_Y;
            DIR_DOWN:  wideY = wideY + ONE_Y;
            default:   ;
        endcase
`ifdef SNAKE_WRAP_EN
        offGrid = 1'b0;
        if (wideX == (XW+1)'(GRID_W))      nextX = '0;
        else if (wideX > (XW+1)'(GRID_W))  nextX = XW'(GRID_W - 1);
        else                               nextX = wideX[XW-1:0];
        if (wideY == (YW+1)'(GRID_H))      nextY = '0;
        else if (wideY > (YW+1)'(GRID_H))  nextY = YW'(GRID_H - 1);
        else                               nextY = wideY[YW-1:0];
`else
        offGrid = (wideX >= (XW+1)'(GRID_W)) || (wideY >= (YW+1)'(GRID_H));
        nextX   = wideX[XW-1:0];
        nextY   = wideY[YW-1:0];
`endif
    end

    assign eatHit    = (nextX == appleX) && (nextY == appleY);
    assign grow      = eatHit && (lenReg < LW'(MAX_LEN));
    // The tail vacates its cell on this move unless the snake grows.
    assign collCount = grow ? lenReg : lenReg - LW'(1);
    assign selfHit   = |(bodyVec & ~MAX_LEN'(1));
    assign candX     = XW'(32'(rand_x) % GRID_W);
    assign candY     = YW'(32'(rand_y) % GRID_H);
    assign candHit   = |candVec;
    assign validReq  = $onehot(dir_req) && (dir_req != oppositeDir(curDir));
    assign restart   = !reset || ((curState == OVER) && start);

    snake_seg_match #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) uBodyMatch (
        .cellX(nextX), .cellY(nextY), .segX(segX), .segY(segY),
        .count(collCount), .match(bodyVec)
    );

    snake_seg_match #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) uQueryMatch (
        .cellX(query_x), .cellY(query_y), .segX(segX), .segY(segY),
        .count(lenReg), .match(queryVec)
    );

    snake_seg_match #(.MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) uCandMatch (
        .cellX(candX), .cellY(candY), .segX(segX), .segY(segY),
        .count(lenReg), .match(candVec)
    );

    always_ff @(posedge clk) begin
        if (!reset) curState <= IDLE;
        else        curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:  if (start) nextState = RUN;
            RUN: begin
                if (tick) begin
                    if (offGrid || selfHit) nextState = OVER;
                    else if (eatHit)        nextState = PLACE;
                end
            end
            PLACE: if (!candHit) nextState = RUN;
            OVER:  if (start) nextState = RUN;
            default: nextState = IDLE;
        endcase
    end

    // Reset and a restart from OVER both load the IDLE layout.
    always_ff @(posedge clk) begin
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= XW'(idleSegX(GRID_W, INIT_LEN, i));
                segY[i] <= YW'(idleHeadY(GRID_H));
            end
            curDir   <= INIT_DIR;
            pendDir  <= INIT_DIR;
            lenReg   <= LW'(INIT_LEN);
            scoreReg <= '0;
            appleX   <= XW'(idleAppleX(GRID_W));
            appleY   <= YW'(idleHeadY(GRID_H));
            ateReg   <= 1'b0;
        end else begin
            ateReg <= 1'b0;
            if (validReq) pendDir <= dir_req;
            if ((curState == RUN) && tick) begin
                curDir <= pendDir;
                if (!(offGrid || selfHit)) begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        segX[i] <= segX[i-1];
                        segY[i] <= segY[i-1];
                    end
                    segX[0] <= nextX;
                    segY[0] <= nextY;
                    if (eatHit) begin
                        ateReg <= 1'b1;
                        if (grow) lenReg <= lenReg + LW'(1);
                        if (scoreReg != 8'hFF) scoreReg <= scoreReg + 8'd1;
                    end
                end
            end else if ((curState == PLACE) && !candHit) begin
                appleX <= candX;
                appleY <= candY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_head  <= 1'b0;
            hit_body  <= 1'b0;
            hit_apple <= 1'b0;
        end else begin
            hit_head  <= queryVec[0];
            hit_body  <= |(queryVec & ~MAX_LEN'(1));
            hit_apple <= (query_x == appleX) && (query_y == appleY);
        end
    end

    assign apple_x = appleX;
    assign apple_y = appleY;
    assign length  = lenReg;
    assign score   = scoreReg;
    assign state   = curState;
    assign ate     = ateReg;

endmodule
